// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
//   Arbitrates the single DDR port between the IFU line fetch and the LSU.
//   Every transaction runs grant (IDLE) -> issue (ISSUE) -> completion
//   (WAIT_DONE). The LSU has priority, but a saturating starvation counter
//   forces an IFU grant after STARVE_MAX back-to-back LSU grants made while
//   the IFU was waiting. An IFU fetch squashed by ifu_flush still completes on
//   DDR, but its done pulse is suppressed so stale lines never reach the
//   ibuffer.
// Ports
//   clock, reset                          : clock and synchronous active-high reset
//   ifu_index_valid/index/flush           : IFU fetch request and squash
//   ifu_index_ready, ifu_operation_done   : IFU capture / line-valid pulses
//   ifu_read_data                         : DDR read line seen by the IFU
//   lsu_req_valid/write/index/wmask/wdata : LSU request
//   lsu_req_ready, lsu_operation_done     : LSU capture / completion pulses
//   lsu_read_data                         : DDR read line seen by the LSU
//   ddr_chip_enable .. ddr_write_data     : registered request to DDR
//   ddr_ready, ddr_operation_done         : DDR accept / completion
//   ddr_read_data                         : DDR read line
//   mem_stall                             : high while the LSU owns the port
module ddr_port_arbiter #(
    parameter int IDX_W      = 19,
    parameter int DATA_W     = 512,
    parameter int MASK_W     = DATA_W / 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_index_valid,
    input  logic [IDX_W-1:0]  ifu_index,
    input  logic              ifu_flush,
    output logic              ifu_index_ready,
    output logic              ifu_operation_done,
    output logic [DATA_W-1:0] ifu_read_data,
    input  logic              lsu_req_valid,
    input  logic              lsu_req_write,
    input  logic [IDX_W-1:0]  lsu_req_index,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              lsu_req_ready,
    output logic              lsu_operation_done,
    output logic [DATA_W-1:0] lsu_read_data,
    output logic              ddr_chip_enable,
    output logic              ddr_write_enable,
    output logic [IDX_W-1:0]  ddr_index,
    output logic [MASK_W-1:0] ddr_write_mask,
    output logic [DATA_W-1:0] ddr_write_data,
    input  logic              ddr_ready,
    input  logic              ddr_operation_done,
    input  logic [DATA_W-1:0] ddr_read_data,
    output logic              mem_stall
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic             owner_lsu;   // 0 = IFU owns the port, 1 = LSU
    logic [CNT_W-1:0] starve_cnt;
    logic             ifu_drop;

    logic idle, lsu_win, ifu_win, done_pulse;

    assign idle    = (state == IDLE);
    assign lsu_win = idle && lsu_req_valid && (!ifu_index_valid || (starve_cnt < STARVE_LIM));
    assign ifu_win = idle && !lsu_win && ifu_index_valid && !ifu_flush;

    // A completion seen together with the accept in ISSUE closes the
    // transaction; any other completion outside WAIT_DONE is ignored.
    assign done_pulse = ddr_operation_done &&
                        ((state == WAIT_DONE) || ((state == ISSUE) && ddr_ready));

    // Pulses are masked during reset so nothing is reported for a
    // transaction that reset is discarding.
    assign lsu_req_ready      = lsu_win && !reset;
    assign ifu_index_ready    = ifu_win && !reset;
    assign lsu_operation_done = done_pulse && owner_lsu && !reset;
    assign ifu_operation_done = done_pulse && !owner_lsu && !ifu_drop && !ifu_flush && !reset;

    assign ifu_read_data   = ddr_read_data;
    assign lsu_read_data   = ddr_read_data;
    assign ddr_chip_enable = (state == ISSUE);
    assign mem_stall       = !idle && owner_lsu;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (lsu_win || ifu_win) state_nxt = ISSUE;
            ISSUE:     if (done_pulse)         state_nxt = IDLE;
                       else if (ddr_ready)     state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_pulse)         state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            owner_lsu        <= 1'b0;
            starve_cnt       <= '0;
            ifu_drop         <= 1'b0;
            ddr_write_enable <= 1'b0;
            ddr_index        <= '0;
            ddr_write_mask   <= '0;
            ddr_write_data   <= '0;
        end else begin
            state <= state_nxt;

            if (lsu_win) begin
                owner_lsu        <= 1'b1;
                ddr_write_enable <= lsu_req_write;
                ddr_index        <= lsu_req_index;
                ddr_write_mask   <= lsu_req_write ? lsu_req_wmask : '0;
                ddr_write_data   <= lsu_req_wdata;
            end else if (ifu_win) begin
                owner_lsu        <= 1'b0;
                ddr_write_enable <= 1'b0;
                ddr_index        <= ifu_index;
                ddr_write_mask   <= '0;
                ddr_write_data   <= '0;
            end

            // Counts LSU grants that overtook a waiting IFU; saturates.
            if (lsu_win && ifu_index_valid) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + CNT_W'(1);
            end else if (ifu_win || (idle && !ifu_index_valid)) begin
                starve_cnt <= '0;
            end

            if (!idle && state_nxt == IDLE)
                ifu_drop <= 1'b0;
            else if (!idle && !owner_lsu && ifu_flush)
                ifu_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter
//   Transaction-level reference model (busy / accepted / owner / dropped plus
//   a starvation tally) checked against the DUT every cycle, directed
//   scenarios with literal expectations, then a randomized phase.
module tb_ddr_port_arbiter;
    localparam int IDX_W = 19, DATA_W = 512, MASK_W = 64, SMAX = 4;

    logic clock = 1'b0, reset = 1'b1;
    logic ifu_index_valid = 0, ifu_flush = 0;
    logic [IDX_W-1:0] ifu_index = '0;
    logic ifu_index_ready, ifu_operation_done;
    logic [DATA_W-1:0] ifu_read_data;
    logic lsu_req_valid = 0, lsu_req_write = 0;
    logic [IDX_W-1:0] lsu_req_index = '0;
    logic [MASK_W-1:0] lsu_req_wmask = '0;
    logic [DATA_W-1:0] lsu_req_wdata = '0;
    logic lsu_req_ready, lsu_operation_done;
    logic [DATA_W-1:0] lsu_read_data;
    logic ddr_chip_enable, ddr_write_enable;
    logic [IDX_W-1:0] ddr_index;
    logic [MASK_W-1:0] ddr_write_mask;
    logic [DATA_W-1:0] ddr_write_data;
    logic ddr_ready = 0, ddr_operation_done = 0;
    logic [DATA_W-1:0] ddr_read_data = '0;
    logic mem_stall;

    always #5 clock = ~clock;

    ddr_port_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .ifu_index_valid(ifu_index_valid), .ifu_index(ifu_index), .ifu_flush(ifu_flush),
        .ifu_index_ready(ifu_index_ready), .ifu_operation_done(ifu_operation_done),
        .ifu_read_data(ifu_read_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_write(lsu_req_write), .lsu_req_index(lsu_req_index),
        .lsu_req_wmask(lsu_req_wmask), .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_ready(lsu_req_ready), .lsu_operation_done(lsu_operation_done),
        .lsu_read_data(lsu_read_data),
        .ddr_chip_enable(ddr_chip_enable), .ddr_write_enable(ddr_write_enable), .ddr_index(ddr_index),
        .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
        .ddr_ready(ddr_ready), .ddr_operation_done(ddr_operation_done), .ddr_read_data(ddr_read_data),
        .mem_stall(mem_stall)
    );

    int n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand512();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic m_busy = 0, m_acc = 0, m_lsu = 0, m_drop = 0;
    int   m_starve = 0;
    logic m_we = 0;
    logic [IDX_W-1:0]  m_idx = '0;
    logic [MASK_W-1:0] m_mask = '0;
    logic [DATA_W-1:0] m_data = '0;

    initial begin
        logic e_lwin, e_iwin, e_done;
        forever begin
            @(negedge clock);
            e_lwin = !m_busy && lsu_req_valid && (!ifu_index_valid || m_starve < SMAX);
            e_iwin = !m_busy && !e_lwin && ifu_index_valid && !ifu_flush;
            e_done = m_busy && ddr_operation_done && (m_acc || ddr_ready);
            if (chk_en) begin
                chk("m_lsu_ready", lsu_req_ready, e_lwin && !reset);
                chk("m_ifu_ready", ifu_index_ready, e_iwin && !reset);
                chk("m_lsu_done", lsu_operation_done, e_done && m_lsu && !reset);
                chk("m_ifu_done", ifu_operation_done, e_done && !m_lsu && !m_drop && !ifu_flush && !reset);
                chk("m_chip_en", ddr_chip_enable, m_busy && !m_acc);
                chk("m_stall", mem_stall, m_busy && m_lsu);
                chk("m_payload", {ddr_write_enable, ddr_index, ddr_write_mask},
                    {m_we, m_idx, m_mask});
                chk("m_wdata", ddr_write_data, m_data);
                chk("m_rdata", ifu_read_data ^ lsu_read_data, '0);
                chk("m_rdata_i", ifu_read_data, ddr_read_data);
            end
            if (reset) begin
                m_busy = 0; m_acc = 0; m_lsu = 0; m_drop = 0; m_starve = 0;
                m_we = 0; m_idx = '0; m_mask = '0; m_data = '0;
            end else if (!m_busy) begin
                if (e_lwin) begin
                    m_busy = 1; m_acc = 0; m_lsu = 1;
                    m_we = lsu_req_write; m_idx = lsu_req_index;
                    m_mask = lsu_req_write ? lsu_req_wmask : '0; m_data = lsu_req_wdata;
                    m_starve = ifu_index_valid ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                end else if (e_iwin) begin
                    m_busy = 1; m_acc = 0; m_lsu = 0;
                    m_we = 0; m_idx = ifu_index; m_mask = '0; m_data = '0;
                    m_starve = 0;
                end else if (!ifu_index_valid) begin
                    m_starve = 0;
                end
            end else if (e_done) begin
                m_busy = 0; m_drop = 0;
            end else begin
                if (ddr_ready) m_acc = 1;
                if (ifu_flush && !m_lsu) m_drop = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int ifu_rate, lsu_rate, flush_rate;
    logic fast_ddr, rst_on;

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic quiesce();
        ifu_index_valid = 0; lsu_req_valid = 0; ifu_flush = 0; reset = 0;
        ddr_ready = 1; ddr_operation_done = 1;
        repeat (3) step();
        ddr_ready = 0; ddr_operation_done = 0;
        step();
    endtask

    // One cycle of autonomous requesters and DDR; requests hold until taken.
    task automatic auto_cycle();
        logic took_i, took_l;
        @(negedge clock);
        took_i = ifu_index_ready;
        took_l = lsu_req_ready;
        @(posedge clock); #1;
        if (!ifu_index_valid || took_i) begin
            ifu_index_valid = ($urandom_range(0, 99) < ifu_rate);
            ifu_index = IDX_W'($urandom);
        end
        if (!lsu_req_valid || took_l) begin
            lsu_req_valid = ($urandom_range(0, 99) < lsu_rate);
            lsu_req_write = fast_ddr ? 1'b1 : 1'($urandom);
            lsu_req_index = IDX_W'($urandom);
            lsu_req_wmask = {$urandom, $urandom};
            lsu_req_wdata = rand512();
        end
        ifu_flush = ($urandom_range(0, 99) < flush_rate);
        reset = rst_on && ($urandom_range(0, 199) == 0);
        ddr_ready = fast_ddr ? 1'b1 : 1'($urandom);
        ddr_operation_done = fast_ddr ? 1'b1 : ($urandom_range(0, 3) == 0);
        ddr_read_data = rand512();
    endtask

    initial begin
        logic [9:0] order;
        logic [DATA_W-1:0] rd;
        logic [IDX_W-1:0] idx2;
        int ng;

        reset = 1;
        repeat (2) @(posedge clock);
        #1; chk_en = 1;
        chk("rst_chip_en", ddr_chip_enable, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_payload", {ddr_write_enable, ddr_index, ddr_write_mask}, '0);
        reset = 0;
        step();

        // IFU alone
        ifu_index_valid = 1; ifu_index = 19'h1234; #1;
        chk("ifu_ready_T", ifu_index_ready, 1);
        step(); ifu_index_valid = 0; ddr_ready = 1; #1;
        chk("ifu_ce_T1", ddr_chip_enable, 1);
        chk("ifu_idx_T1", ddr_index, 19'h1234);
        chk("ifu_we_T1", ddr_write_enable, 0);
        step(); ddr_ready = 0; #1;
        chk("ifu_ce_T2", ddr_chip_enable, 0);
        step();
        step(); rd = rand512(); ddr_read_data = rd; ddr_operation_done = 1; #1;
        chk("ifu_done_T4", ifu_operation_done, 1);
        chk("ifu_data_T4", ifu_read_data, rd);
        chk("ifu_stall_T4", mem_stall, 0);
        step(); ddr_operation_done = 0; #1;
        chk("ifu_done_T5", ifu_operation_done, 0);
        step();

        // Starvation: both requesting continuously, DDR answers instantly.
        ifu_rate = 100; lsu_rate = 100; flush_rate = 0; fast_ddr = 1; rst_on = 0;
        order = '0; ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            auto_cycle(); #1;
            if (lsu_req_ready) begin order = {order[8:0], 1'b1}; ng++; end
            else if (ifu_index_ready) begin order = {order[8:0], 1'b0}; ng++; end
        end
        chk("grant_count", ng, 10);
        chk("grant_order", order, 10'b1111011110);
        quiesce();

        // LSU write
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_index = 19'h2A5A5;
        lsu_req_wmask = 64'h0F; lsu_req_wdata = {64{8'hAA}}; #1;
        chk("lsu_ready_T", lsu_req_ready, 1);
        step(); lsu_req_valid = 0; lsu_req_write = 0; lsu_req_wmask = '0; lsu_req_wdata = '0;
        ddr_ready = 1; #1;
        chk("lsu_we", ddr_write_enable, 1);
        chk("lsu_mask", ddr_write_mask, 64'h0F);
        chk("lsu_wdata", ddr_write_data, {64{8'hAA}});
        chk("lsu_stall", mem_stall, 1);
        step(); ddr_ready = 0; ddr_operation_done = 1; #1;
        chk("lsu_done", lsu_operation_done, 1);
        step(); ddr_operation_done = 0; #1;
        chk("lsu_done_once", lsu_operation_done, 0);
        chk("lsu_stall_end", mem_stall, 0);
        step();

        // Flush two cycles before completion
        ifu_index_valid = 1; ifu_index = 19'h00777; #1;
        chk("fl_grant", ifu_index_ready, 1);
        step(); ifu_index_valid = 0; ddr_ready = 1;
        step(); ddr_ready = 0;
        step(); ifu_flush = 1;
        step(); ifu_flush = 0;
        idx2 = 19'h00778;
        step(); ddr_operation_done = 1; ifu_index_valid = 1; ifu_index = idx2; #1;
        chk("fl_no_done", ifu_operation_done, 0);
        step(); ddr_operation_done = 0; #1;
        chk("fl_next_grant", ifu_index_ready, 1);
        // Flush coincident with completion
        step(); ifu_index_valid = 0; ddr_ready = 1;
        step(); ddr_ready = 0; ddr_operation_done = 1; ifu_flush = 1; #1;
        chk("fl_same_cycle", ifu_operation_done, 0);
        step(); ddr_operation_done = 0; ifu_flush = 0;
        step();

        // Reset during ISSUE
        ifu_index_valid = 1; ifu_index = 19'h7FFFF; #1;
        chk("rs_grant", ifu_index_ready, 1);
        step(); ifu_index_valid = 0; reset = 1; #1;
        chk("rs_ce_issue", ddr_chip_enable, 1);
        step(); reset = 0; #1;
        chk("rs_ce_after", ddr_chip_enable, 0);
        chk("rs_idx_after", ddr_index, 0);
        step(); ddr_ready = 1; ddr_operation_done = 1; #1;
        chk("rs_stray_ifu", ifu_operation_done, 0);
        chk("rs_stray_lsu", lsu_operation_done, 0);
        step(); ddr_ready = 0; ddr_operation_done = 0;
        step();

        // Randomized traffic
        ifu_rate = 60; lsu_rate = 50; flush_rate = 10; fast_ddr = 0; rst_on = 1;
        repeat (3000) auto_cycle();
        quiesce();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
